// File: rtl/add_seq_ctl.sv
// +------------------------------------------------------------------------+
// | Module   : add_seq_ctl (with cla16 slice adder)                        |
// | Desc     : WORDS*16-bit add/subtract sequenced through one 16-bit CLA  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_cg;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Second-level lookahead across the four 4-bit groups
  assign w_cg[0] = cin;
  assign w_cg[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
  assign w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign w_cg[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

  generate
    for (genvar k = 0; k < 4; k++) begin : g_grp
      logic [3:0] w_gk;
      logic [3:0] w_pk;
      logic       w_ci;

      assign w_gk = w_g[4*k +: 4];
      assign w_pk = w_p[4*k +: 4];
      assign w_ci = w_cg[k];

      assign w_c[4*k]     = w_ci;
      assign w_c[4*k + 1] = w_gk[0] | (w_pk[0] & w_ci);
      assign w_c[4*k + 2] = w_gk[1] | (w_pk[1] & w_gk[0]) | (w_pk[1] & w_pk[0] & w_ci);
      assign w_c[4*k + 3] = w_gk[2] | (w_pk[2] & w_gk[1]) | (w_pk[2] & w_pk[1] & w_gk[0])
                          | (w_pk[2] & w_pk[1] & w_pk[0] & w_ci);

      assign w_gg[k] = w_gk[3] | (w_pk[3] & w_gk[2]) | (w_pk[3] & w_pk[2] & w_gk[1])
                     | (w_pk[3] & w_pk[2] & w_pk[1] & w_gk[0]);
      assign w_gp[k] = &w_pk;
    end
  endgenerate

  assign s    = w_p ^ w_c;
  assign cout = w_cg[4];

endmodule

module add_seq_ctl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int c_W  = 16 * WORDS;
  localparam int c_IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(WORDS - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_W-1:0]  r_a;
  logic [c_W-1:0]  r_b;
  logic            r_carry;
  logic [c_IW-1:0] r_idx;
  logic [c_W-1:0]  r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [15:0]     w_slice_s;
  logic            w_slice_co;
  logic [c_W-1:0]  w_sum_shift;
  logic            w_last;
  logic            w_in_ready;
  logic            w_out_valid;

  cla16 u_cla16 (
    .a    (r_a[15:0]),
    .b    (r_b[15:0]),
    .cin  (r_carry),
    .s    (w_slice_s),
    .cout (w_slice_co)
  );

  assign w_last = (r_idx == c_LAST);

  // New slice enters at the top so the LSB slice ends up at the bottom
  generate
    if (WORDS == 1) begin : g_single
      assign w_sum_shift = w_slice_s;
    end else begin : g_multi
      assign w_sum_shift = {w_slice_s, r_sum[c_W-1:16]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (in_valid)  w_state_nxt = c_RUN;
      c_RUN:   if (w_last)    w_state_nxt = c_DONE;
      c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      c_IDLE:  w_in_ready  = 1'b1;
      c_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
          end
        end
        c_RUN: begin
          r_sum   <= w_sum_shift;
          r_a     <= r_a >> 16;
          r_b     <= r_b >> 16;
          r_carry <= w_slice_co;
          r_idx   <= r_idx + c_IW'(1);
          // Top slice: operand MSBs are still at bit 15 of the shifted regs
          if (w_last) begin
            r_cout <= w_slice_co;
            r_ovf  <= (r_a[15] == r_b[15]) && (w_slice_s[15] != r_a[15]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_add_seq_ctl.sv
// +------------------------------------------------------------------------+
// | Module   : tb_add_seq_ctl                                              |
// | Desc     : Directed scoreboard bench for add_seq_ctl (WORDS=4 and 1)   |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_add_seq_ctl;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  logic        in_valid1;
  logic        in_ready1;
  logic        sub1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        out_valid1;
  logic        out_ready1;
  logic [15:0] sum1;
  logic        cout1;
  logic        ovf1;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e_cur;
  int   n_assert = 0;
  int   n_fail   = 0;

  add_seq_ctl #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  add_seq_ctl #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .sub(sub1), .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic on a w-bit operand width
  function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic ms, input int w);
    logic [64:0] mask;
    logic [64:0] t;
    logic [63:0] be;
    logic [63:0] am;
    exp_t r;
    mask = (65'd1 << w) - 65'd1;
    am   = ma & mask[63:0];
    be   = (ms ? ~mb : mb) & mask[63:0];
    t    = {1'b0, am} + {1'b0, be} + 65'(ms);
    r.sum  = t[63:0] & mask[63:0];
    r.cout = t[w];
    r.ovf  = (am[w-1] == be[w-1]) && (t[w-1] != am[w-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch4(input logic [63:0] ta, input logic [63:0] tb2, input logic ts,
                         input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = ta; b = tb2; sub = ts;
    q4.push_back(model(ta, tb2, ts, 64));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the first negedge after the accept edge
  task automatic collect4(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
    e_cur = q4.pop_front();
    check({tag, "_sum"},  sum,         e_cur.sum);
    check({tag, "_cout"}, 64'(cout),   64'(e_cur.cout));
    check({tag, "_ovf"},  64'(ovf),    64'(e_cur.ovf));
  endtask

  task automatic release4(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"},    64'(in_ready),  64'd1);
  endtask

  task automatic run4(input logic [63:0] ta, input logic [63:0] tb2, input logic ts,
                      input string tag);
    launch4(ta, tb2, ts, tag);
    collect4(tag);
    release4(tag);
  endtask

  task automatic run1(input logic [15:0] ta, input logic [15:0] tb2, input logic ts,
                      input string tag);
    int n;
    exp_t e;
    check({tag, "_in_ready"}, 64'(in_ready1), 64'd1);
    in_valid1 = 1'b1; a1 = ta; b1 = tb2; sub1 = ts;
    q1.push_back(model(64'(ta), 64'(tb2), ts, 16));
    @(negedge clk);
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd1);
    e = q1.pop_front();
    check({tag, "_sum"},  64'(sum1),  e.sum);
    check({tag, "_cout"}, 64'(cout1), 64'(e.cout));
    check({tag, "_ovf"},  64'(ovf1),  64'(e.ovf));
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check({tag, "_ov_drop"}, 64'(out_valid1), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       sum,            64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run4(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, "add_carry16");
    run4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_wrap");
    run4(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_ovf");
    run4(64'd5, 64'd7, 1'b1, "sub_borrow");
    run4(64'd7, 64'd5, 1'b1, "sub_pos");
    run4(64'h8000_0000_0000_0000, 64'd1, 1'b1, "sub_ovf");
    run4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, "add_mix");

    // Backpressure: outputs frozen, no new accept while DONE
    launch4(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b1, "bp");
    collect4("bp");
    for (int h = 0; h < 3; h++) begin
      in_valid = (h % 2 == 0);
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = $urandom_range(0, 1);
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_sum_hold",  sum,            e_cur.sum);
      check("bp_cout_hold", 64'(cout),      64'(e_cur.cout));
      check("bp_ovf_hold",  64'(ovf),       64'(e_cur.ovf));
    end
    // in_valid with out_ready in DONE: only the output handshake happens
    in_valid = 1'b1; a = 64'd10; b = 64'd20; sub = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_ov",    64'(out_valid), 64'd0);
    check("bp_rel_ready", 64'(in_ready),  64'd1);
    q4.push_back(model(64'd10, 64'd20, 1'b0, 64));
    @(negedge clk);
    in_valid = 1'b0;
    collect4("bp_next");
    release4("bp_next");

    // Reset during RUN discards the operation
    in_valid = 1'b1; a = 64'hAAAA_BBBB_CCCC_DDDD; b = 64'h1111_2222_3333_4444; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_in_ready",  64'(in_ready),  64'd1);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_sum",       sum,            64'd0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    check("mrst_no_result", 64'(out_valid), 64'd0);
    run4(64'd3, 64'd4, 1'b0, "post_rst");

    run1(16'hFFFF, 16'h0001, 1'b0, "w1_wrap");
    run1(16'h7FFF, 16'h0001, 1'b0, "w1_ovf");
    run1(16'h0005, 16'h0007, 1'b1, "w1_sub");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
